// File: rtl/xcr_cr_master_if.sv
// Bundle of request/response port and XCR control-register bus signals.
// The master modport is the view of xcr_cr_master. The slave modport is the
// view of whatever sits around it: the request source and the register block.
interface xcr_cr_master_if;
  // request port
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_adr;
  logic [1:0]  req_len;
  logic [31:0] req_wdata;
  // response port
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;
  // cr bus
  logic [7:0]  cr_din;
  logic [7:0]  cr_dout;
  logic [7:0]  cr_adr;
  logic        cr_we;
  logic        cr_cs;

  modport master (
    input  req_valid, req_we, req_adr, req_len, req_wdata, cr_dout,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
           cr_din, cr_adr, cr_we, cr_cs
  );

  modport slave (
    output req_valid, req_we, req_adr, req_len, req_wdata, cr_dout,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
           cr_din, cr_adr, cr_we, cr_cs
  );
endinterface

// File: rtl/xcr_cr_master.sv
// Initiator for the 8-bit XCR control-register bus. Takes a 1-4 byte
// read/write request, issues one single-byte cr beat per cycle, and returns
// a single-cycle response strobe. All bus and response outputs are registered.
module xcr_cr_master #(
  parameter logic [15:0] MAP_MASK = 16'h0003
) (
  input logic            clk,
  input logic            rst,
  xcr_cr_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  // registered state
  state_t      r_state;
  logic        r_we;
  logic [7:0]  r_base;
  logic [1:0]  r_len;
  logic [31:0] r_wdata;
  logic [1:0]  r_idx;
  logic [31:0] r_acc;
  logic        r_cs;
  logic        r_wr;
  logic [7:0]  r_adr;
  logic [7:0]  r_din;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic        r_busy;

  // combinational next values
  state_t      w_state_next;
  logic        w_we_next;
  logic [7:0]  w_base_next;
  logic [1:0]  w_len_next;
  logic [31:0] w_wdata_next;
  logic [1:0]  w_idx_next;
  logic [31:0] w_acc_next;
  logic        w_cs_next;
  logic        w_wr_next;
  logic [7:0]  w_adr_next;
  logic [7:0]  w_din_next;
  logic        w_rsp_valid_next;
  logic        w_rsp_err_next;
  logic [31:0] w_rsp_rdata_next;

  logic        w_ready;
  logic        w_accept;
  logic [4:0]  w_span;
  logic        w_req_err;
  logic [1:0]  w_idx_inc;
  logic [31:0] w_acc_merged;

  assign w_ready   = (r_state == IDLE) && !rst;
  assign w_accept  = bus.req_valid && w_ready;
  // Last byte offset inside the 16-byte window; bit 4 set means the request
  // runs past the end of the window (0xFF+1 wrap lands here too).
  assign w_span    = {1'b0, bus.req_adr[3:0]} + {3'b000, bus.req_len};
  assign w_req_err = !MAP_MASK[bus.req_adr[7:4]] || w_span[4];
  assign w_idx_inc = r_idx + 2'd1;

  // Read accumulator with the current beat's byte merged into its lane;
  // writes never touch the accumulator so their response data stays zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_acc_merged[8*gi +: 8] = (!r_we && (r_idx == 2'(gi))) ?
                                       bus.cr_dout : r_acc[8*gi +: 8];
    end
  endgenerate

  // Next-state and next-output decode
  always_comb begin
    w_state_next     = r_state;
    w_we_next        = r_we;
    w_base_next      = r_base;
    w_len_next       = r_len;
    w_wdata_next     = r_wdata;
    w_idx_next       = r_idx;
    w_acc_next       = r_acc;
    w_cs_next        = 1'b0;
    w_wr_next        = 1'b0;
    w_adr_next       = r_adr;
    w_din_next       = 8'h00;
    w_rsp_valid_next = 1'b0;
    w_rsp_err_next   = r_rsp_err;
    w_rsp_rdata_next = r_rsp_rdata;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_we_next        = bus.req_we;
          w_base_next      = bus.req_adr;
          w_len_next       = bus.req_len;
          w_wdata_next     = bus.req_wdata;
          w_idx_next       = 2'd0;
          w_acc_next       = 32'h0;
          w_rsp_rdata_next = 32'h0;
          if (w_req_err) begin
            w_state_next     = RESP;
            w_rsp_valid_next = 1'b1;
            w_rsp_err_next   = 1'b1;
          end else begin
            w_state_next   = XFER;
            w_rsp_err_next = 1'b0;
            w_cs_next      = 1'b1;
            w_wr_next      = bus.req_we;
            w_adr_next     = bus.req_adr;
            w_din_next     = bus.req_we ? bus.req_wdata[7:0] : 8'h00;
          end
        end
      end
      XFER: begin
        w_acc_next = w_acc_merged;
        if (r_idx == r_len) begin
          w_state_next     = RESP;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = w_acc_merged;
        end else begin
          w_idx_next = w_idx_inc;
          w_cs_next  = 1'b1;
          w_wr_next  = r_we;
          w_adr_next = r_base + {6'b000000, w_idx_inc};
          w_din_next = r_we ? r_wdata[{w_idx_inc, 3'b000} +: 8] : 8'h00;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_base      <= 8'h00;
      r_len       <= 2'd0;
      r_wdata     <= 32'h0;
      r_idx       <= 2'd0;
      r_acc       <= 32'h0;
      r_cs        <= 1'b0;
      r_wr        <= 1'b0;
      r_adr       <= 8'h00;
      r_din       <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_we        <= w_we_next;
      r_base      <= w_base_next;
      r_len       <= w_len_next;
      r_wdata     <= w_wdata_next;
      r_idx       <= w_idx_next;
      r_acc       <= w_acc_next;
      r_cs        <= w_cs_next;
      r_wr        <= w_wr_next;
      r_adr       <= w_adr_next;
      r_din       <= w_din_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_err   <= w_rsp_err_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_busy      <= (w_state_next != IDLE);
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.busy      = r_busy;
  assign bus.cr_cs     = r_cs;
  assign bus.cr_we     = r_wr;
  assign bus.cr_adr    = r_adr;
  assign bus.cr_din    = r_din;

endmodule

// File: tb/tb_xcr_cr_master.sv
// Directed bench for xcr_cr_master: a vector table of single requests,
// then hand-written sequences for reset mid-transfer, back-to-back accepts
// and a fully-mapped instance for the 0xFF wrap case.
module tb_xcr_cr_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  xcr_cr_master_if if0 ();
  xcr_cr_master_if if1 ();

  xcr_cr_master #(.MAP_MASK(16'h0003)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  xcr_cr_master #(.MAP_MASK(16'hFFFF)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Responder: fixed bytes at 0x04/0x05, otherwise address xor 0xA5
  function automatic logic [7:0] resp_byte(input logic [7:0] a);
    case (a)
      8'h04:   return 8'h5A;
      8'h05:   return 8'h3C;
      default: return a ^ 8'hA5;
    endcase
  endfunction

  always_comb if0.cr_dout = resp_byte(if0.cr_adr);
  always_comb if1.cr_dout = resp_byte(if1.cr_adr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  // One request on dut0, checked cycle by cycle from accept to return to IDLE
  task automatic run_req(input int id, input logic we, input logic [7:0] adr,
                         input logic [1:0] len, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata);
    int nb;
    int last;
    logic [31:0] wd;
    wd = wdata;
    @(posedge clk); #1;
    if0.req_valid = 1'b1;
    if0.req_we    = we;
    if0.req_adr   = adr;
    if0.req_len   = len;
    if0.req_wdata = wdata;
    check($sformatf("v%0d ready_before", id), 32'(if0.req_ready), 32'd1);
    @(posedge clk); #1;
    // scramble request lines; they must be ignored outside IDLE
    if0.req_valid = 1'b0;
    if0.req_we    = ~we;
    if0.req_adr   = 8'hEE;
    if0.req_len   = 2'd3;
    if0.req_wdata = 32'hDEADBEEF;
    nb   = exp_err ? 0 : int'(len) + 1;
    last = exp_err ? 1 : int'(len) + 2;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      if (k <= nb) begin
        check($sformatf("v%0d c%0d cs", id, k), 32'(if0.cr_cs), 32'd1);
        check($sformatf("v%0d c%0d we", id, k), 32'(if0.cr_we), 32'(we));
        check($sformatf("v%0d c%0d adr", id, k), 32'(if0.cr_adr), 32'(adr + 8'(k - 1)));
        check($sformatf("v%0d c%0d din", id, k), 32'(if0.cr_din),
              we ? 32'(wd[8*(k-1) +: 8]) : 32'd0);
        check($sformatf("v%0d c%0d rsp_valid", id, k), 32'(if0.rsp_valid), 32'd0);
        check($sformatf("v%0d c%0d ready", id, k), 32'(if0.req_ready), 32'd0);
        check($sformatf("v%0d c%0d busy", id, k), 32'(if0.busy), 32'd1);
      end else if (k == last) begin
        check($sformatf("v%0d c%0d rsp_valid", id, k), 32'(if0.rsp_valid), 32'd1);
        check($sformatf("v%0d c%0d rsp_err", id, k), 32'(if0.rsp_err), 32'(exp_err));
        check($sformatf("v%0d c%0d rsp_rdata", id, k), if0.rsp_rdata, exp_rdata);
        check($sformatf("v%0d c%0d cs_resp", id, k), 32'(if0.cr_cs), 32'd0);
        check($sformatf("v%0d c%0d we_resp", id, k), 32'(if0.cr_we), 32'd0);
        check($sformatf("v%0d c%0d busy_resp", id, k), 32'(if0.busy), 32'd1);
        check($sformatf("v%0d c%0d ready_resp", id, k), 32'(if0.req_ready), 32'd0);
      end else begin
        check($sformatf("v%0d c%0d rsp_valid_off", id, k), 32'(if0.rsp_valid), 32'd0);
        check($sformatf("v%0d c%0d busy_idle", id, k), 32'(if0.busy), 32'd0);
        check($sformatf("v%0d c%0d ready_idle", id, k), 32'(if0.req_ready), 32'd1);
        check($sformatf("v%0d c%0d err_held", id, k), 32'(if0.rsp_err), 32'(exp_err));
        check($sformatf("v%0d c%0d rdata_held", id, k), if0.rsp_rdata, exp_rdata);
        check($sformatf("v%0d c%0d cs_idle", id, k), 32'(if0.cr_cs), 32'd0);
      end
    end
    $display("txn v%0d we=%0d adr=0x%02h len=%0d err=%0d rdata=0x%08h",
             id, we, adr, len, if0.rsp_err, if0.rsp_rdata);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 8'h10, 2'd3, 32'hA1B2C3D4, 1'b0, 32'h00000000};
    vecs[1] = '{1'b0, 8'h04, 2'd1, 32'h00000000, 1'b0, 32'h00003C5A};
    vecs[2] = '{1'b0, 8'h0E, 2'd3, 32'h00000000, 1'b1, 32'h00000000};
    vecs[3] = '{1'b0, 8'h20, 2'd0, 32'h00000000, 1'b1, 32'h00000000};
    vecs[4] = '{1'b0, 8'h1F, 2'd0, 32'h00000000, 1'b0, 32'h000000BA};
    vecs[5] = '{1'b0, 8'h08, 2'd3, 32'h00000000, 1'b0, 32'hAEAFACAD};
    vecs[6] = '{1'b1, 8'h0C, 2'd3, 32'h11223344, 1'b0, 32'h00000000};
    vecs[7] = '{1'b0, 8'h1D, 2'd3, 32'h00000000, 1'b1, 32'h00000000};
    vecs[8] = '{1'b1, 8'h30, 2'd0, 32'h000000FF, 1'b1, 32'h00000000};
    vecs[9] = '{1'b0, 8'h00, 2'd0, 32'h00000000, 1'b0, 32'h000000A5};

    if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_adr = 8'h00;
    if0.req_len = 2'd0; if0.req_wdata = 32'h0;
    if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_adr = 8'h00;
    if1.req_len = 2'd0; if1.req_wdata = 32'h0;

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst cs", 32'(if0.cr_cs), 32'd0);
    check("rst we", 32'(if0.cr_we), 32'd0);
    check("rst adr", 32'(if0.cr_adr), 32'd0);
    check("rst din", 32'(if0.cr_din), 32'd0);
    check("rst rsp_valid", 32'(if0.rsp_valid), 32'd0);
    check("rst rsp_err", 32'(if0.rsp_err), 32'd0);
    check("rst rsp_rdata", if0.rsp_rdata, 32'd0);
    check("rst busy", 32'(if0.busy), 32'd0);
    check("rst ready", 32'(if0.req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst ready", 32'(if0.req_ready), 32'd1);

    // vector table
    for (int v = 0; v < 10; v++)
      run_req(v, vecs[v].we, vecs[v].adr, vecs[v].len, vecs[v].wdata,
              vecs[v].exp_err, vecs[v].exp_rdata);

    // reset in the middle of a 4-byte write
    @(posedge clk); #1;
    if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_adr = 8'h00;
    if0.req_len = 2'd3; if0.req_wdata = 32'h44332211;
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    @(negedge clk);
    check("rstmid c1 cs", 32'(if0.cr_cs), 32'd1);
    check("rstmid c1 adr", 32'(if0.cr_adr), 32'h00);
    @(negedge clk);
    check("rstmid c2 cs", 32'(if0.cr_cs), 32'd1);
    check("rstmid c2 adr", 32'(if0.cr_adr), 32'h01);
    check("rstmid c2 din", 32'(if0.cr_din), 32'h22);
    rst = 1'b1;
    #1;
    check("rstmid ready_in_rst", 32'(if0.req_ready), 32'd0);
    @(negedge clk);
    check("rstmid c3 cs", 32'(if0.cr_cs), 32'd0);
    check("rstmid c3 we", 32'(if0.cr_we), 32'd0);
    check("rstmid c3 busy", 32'(if0.busy), 32'd0);
    check("rstmid c3 rsp_valid", 32'(if0.rsp_valid), 32'd0);
    rst = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("rstmid c%0d ready", k), 32'(if0.req_ready), 32'd1);
      check($sformatf("rstmid c%0d cs", k), 32'(if0.cr_cs), 32'd0);
      check($sformatf("rstmid c%0d rsp_valid", k), 32'(if0.rsp_valid), 32'd0);
    end
    $display("txn reset-mid-write aborted, no response");
    run_req(20, 1'b0, 8'h05, 2'd0, 32'h0, 1'b0, 32'h0000003C);

    // back-to-back 1-byte writes with req_valid held high
    @(posedge clk); #1;
    if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_adr = 8'h11;
    if0.req_len = 2'd0; if0.req_wdata = 32'h00000077;
    @(posedge clk); #1;
    if0.req_adr = 8'h12; if0.req_wdata = 32'h00000088;
    for (int k = 1; k <= 6; k++) begin
      logic e_cs, e_rv, e_rdy;
      logic [7:0] e_adr, e_din;
      e_cs  = (k == 1) || (k == 4);
      e_rv  = (k == 2) || (k == 5);
      e_rdy = (k == 3) || (k == 6);
      e_adr = (k >= 4) ? 8'h12 : 8'h11;
      e_din = (k == 1) ? 8'h77 : ((k == 4) ? 8'h88 : 8'h00);
      @(negedge clk);
      check($sformatf("b2b c%0d cs", k), 32'(if0.cr_cs), 32'(e_cs));
      check($sformatf("b2b c%0d rsp_valid", k), 32'(if0.rsp_valid), 32'(e_rv));
      check($sformatf("b2b c%0d ready", k), 32'(if0.req_ready), 32'(e_rdy));
      if (e_cs) begin
        check($sformatf("b2b c%0d adr", k), 32'(if0.cr_adr), 32'(e_adr));
        check($sformatf("b2b c%0d din", k), 32'(if0.cr_din), 32'(e_din));
        check($sformatf("b2b c%0d we", k), 32'(if0.cr_we), 32'd1);
      end
      if (e_rv) check($sformatf("b2b c%0d err", k), 32'(if0.rsp_err), 32'd0);
      if (k == 3) begin
        @(posedge clk); #1;
        if0.req_valid = 1'b0;
      end
    end
    $display("txn back-to-back writes 0x11/0x12 done");

    // fully mapped instance: 0xFF wrap errors, window 2 is reachable
    @(posedge clk); #1;
    if1.req_valid = 1'b1; if1.req_we = 1'b0; if1.req_adr = 8'hFF; if1.req_len = 2'd1;
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    @(negedge clk);
    check("full ff rsp_valid", 32'(if1.rsp_valid), 32'd1);
    check("full ff rsp_err", 32'(if1.rsp_err), 32'd1);
    check("full ff rdata", if1.rsp_rdata, 32'd0);
    check("full ff cs", 32'(if1.cr_cs), 32'd0);
    $display("txn full-map adr=0xFF len=1 err=%0d", if1.rsp_err);
    @(posedge clk); #1;
    if1.req_valid = 1'b1; if1.req_adr = 8'h20; if1.req_len = 2'd0;
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    @(negedge clk);
    check("full 20 cs", 32'(if1.cr_cs), 32'd1);
    check("full 20 adr", 32'(if1.cr_adr), 32'h20);
    @(negedge clk);
    check("full 20 rsp_valid", 32'(if1.rsp_valid), 32'd1);
    check("full 20 rsp_err", 32'(if1.rsp_err), 32'd0);
    check("full 20 rdata", if1.rsp_rdata, 32'h00000085);
    $display("txn full-map adr=0x20 len=0 rdata=0x%08h", if1.rsp_rdata);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
